id_ex_stage: RTL and testbench
==============================

// Module: id_ex_stage
// PURPOSE
//  Parametrised ID->EX pipeline stage. Carries one decoded-instruction payload per beat
//  over a valid/ready handshake, with stall, flush and bubble squashing. Optionally adds
//  a 2-entry skid buffer so that in_ready is registered (timing break on the ready path).
//  Sits between the decoder and the ALU/branch unit. Replaces the fixed-field ID/EX latch.
// PARAMETERS
//  PW       145  payload width in bits (t,st,sst,n1,n2,wa,we,nn,npc packed, t at MSBs)
//  OPC_W    7    opcode field width; field occupies in_data[PW-1 -: OPC_W]
//  BUB_OPC  0    opcode value treated as a bubble (never stored)
//  CNT_W    16   width of the squashed-bubble counter
// PORTS
//  clk        in   1      clock, all state updates on posedge
//  rst        in   1      synchronous, active-high reset
//  in_valid   in   1      ID presents a payload
//  in_ready   out  1      stage can accept this cycle
//  in_data    in   PW     ID payload
//  out_valid  out  1      EX payload valid
//  out_ready  in   1      EX consumes this cycle
//  out_data   out  PW     EX payload (head entry)
//  stl_mm     in   1      memory stall: freezes the stage, same effect as out_ready=0
//  flush      in   1      branch/exception kill: drop every held entry
//  occ        out  2      entries held (0..1 without skid, 0..2 with)
//  bub_cnt    out  CNT_W  number of bubbles squashed since reset, saturating
// BEHAVIOUR
//  - Reset: out_valid=0, out_data=0, occ=0, bub_cnt=0. in_ready=1 in the cycle after reset deasserts.
//  - Accept = in_valid & in_ready. Drain = out_valid & out_ready & !stl_mm.
//  - Bubble: an accepted beat whose opcode field == BUB_OPC is consumed but not stored.
//    bub_cnt += 1, saturating at all-ones.
//  - Latency: a stored beat is on out_data the cycle after acceptance (1 cycle).
//  - Order: strict FIFO; out_data is always the oldest held entry.
//  - out_data holds its value while out_valid & !drain. When empty it keeps its last value;
//    the verifier checks out_data only under out_valid.
//  - Flush (wins over everything except rst): all entries invalidated next cycle, occ=0.
//    A beat presented in the same cycle is discarded, not stored; bub_cnt is unchanged.
//    in_ready may still read 1 during flush.
//  - Stall and flush together: flush wins.
//  - Stall alone: no drain; accepts are still allowed while space remains.
//  - Single-register mode (no macro):
//    - States EMPTY/ONE.
//    - in_ready = !out_valid | (out_ready & !stl_mm): combinational pass-through of out_ready.
//    - Simultaneous drain+accept in ONE stays in ONE and loads the new beat; full throughput.
// CONFIGURATION
//  ID_EX_SKID_EN defined:
//   - States EMPTY->ONE on an accepted non-bubble beat.
//   - ONE->TWO on accept & !drain.
//   - TWO->ONE on drain.
//   - ONE->EMPTY on drain & !accept.
//   - Any state ->EMPTY on flush or rst.
//   - in_ready = (state!=TWO), driven from a flop with no combinational path from
//     out_ready/stl_mm.
//   - In TWO, drain promotes the skid entry to head the next cycle.
//   - Accept in TWO never occurs, because in_ready is 0.
//  ID_EX_SKID_EN undefined: the single-register mode above; occ never exceeds 1.
// STRUCTURE
//  - id_ex_pkg holds:
//    - the payload field widths/offsets (T_W=7, ST_W=3, WA_W=5, XLEN=32) and the derived PW;
//    - the localparam state encoding (ST_EMPTY=0, ST_ONE=1, ST_TWO=2);
//    - the pack/unpack functions.
//  - One sub-module, id_ex_skid: the 2-entry head/skid storage plus the state machine,
//    instantiated only under ID_EX_SKID_EN.
//  - The top holds the bubble detection, flush gating and counter.
// TESTING
//  1 Reset with in_valid=1 and t=7'h13 -> out_valid=0, occ=0.
//    After rst falls, the beat appears on out_data one cycle later.
//  2 Stream 0x11,0x22,0x33 with out_ready=1 -> same order out, one per cycle.
//    occ never exceeds 1 (either mode).
//  3 Hold out_ready=0, push 0x11,0x22 -> skid mode: occ=2, in_ready=0.
//    Release out_ready -> 0x11 then 0x22 out, with no loss and no duplication.
//  4 Push t=7'h00 beats x3 between real beats -> none reach EX, bub_cnt=3.
//  5 flush while occ=2 and a new beat is offered -> next cycle out_valid=0, occ=0.
//    The offered beat never appears on out_data.
//  6 stl_mm=1 with out_ready=1 for 4 cycles -> out_data stable, no drain.
//    Drain resumes the cycle after stl_mm falls.

Source files
------------

// File: rtl/id_ex_pkg.sv
// Shared definitions for the ID->EX pipeline stage: payload field widths,
// the derived payload width, the state encoding and payload pack/unpack helpers.
package id_ex_pkg;

    // Payload field widths
    localparam int T_W   = 7;   // opcode / type field
    localparam int ST_W  = 3;   // sub-type
    localparam int SST_W = 1;   // sub-sub-type flag
    localparam int WA_W  = 5;   // write-back register address
    localparam int WE_W  = 1;   // write enable
    localparam int XLEN  = 32;  // operand / pc width

    // t,st,sst,n1,n2,wa,we,nn,npc packed with t at the MSBs
    localparam int ID_EX_PW = T_W + ST_W + SST_W + 4 * XLEN + WA_W + WE_W;

    // Bit offsets (LSB position) of each field inside the packed payload
    localparam int NPC_LSB = 0;
    localparam int NN_LSB  = NPC_LSB + XLEN;
    localparam int WE_LSB  = NN_LSB + XLEN;
    localparam int WA_LSB  = WE_LSB + WE_W;
    localparam int N2_LSB  = WA_LSB + WA_W;
    localparam int N1_LSB  = N2_LSB + XLEN;
    localparam int SST_LSB = N1_LSB + XLEN;
    localparam int ST_LSB  = SST_LSB + SST_W;
    localparam int T_LSB   = ST_LSB + ST_W;

    // State encoding; the numeric value equals the number of held entries
    localparam logic [1:0] ST_EMPTY = 2'd0;
    localparam logic [1:0] ST_ONE   = 2'd1;
    localparam logic [1:0] ST_TWO   = 2'd2;

    typedef enum logic [1:0] {
        S_EMPTY = ST_EMPTY,
        S_ONE   = ST_ONE,
        S_TWO   = ST_TWO
    } id_ex_state_e;

    typedef struct packed {
        logic [T_W-1:0]   t;
        logic [ST_W-1:0]  st;
        logic [SST_W-1:0] sst;
        logic [XLEN-1:0]  n1;
        logic [XLEN-1:0]  n2;
        logic [WA_W-1:0]  wa;
        logic [WE_W-1:0]  we;
        logic [XLEN-1:0]  nn;
        logic [XLEN-1:0]  npc;
    } id_ex_payload_t;

    function automatic logic [ID_EX_PW-1:0] pack(input id_ex_payload_t p);
        return p;
    endfunction

    function automatic id_ex_payload_t unpack(input logic [ID_EX_PW-1:0] d);
        return d;
    endfunction

endpackage

// File: rtl/id_ex_skid.sv
// Two-entry head/skid storage with its EMPTY/ONE/TWO state machine.
// in_ready_o comes straight from a flop so the upstream ready path has no
// combinational dependency on the downstream ready or the memory stall.
// occ_o is the state register itself, so it doubles as the FSM debug view.
module id_ex_skid
    import id_ex_pkg::*;
#(
    parameter int PW = ID_EX_PW
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          flush_i,     // drop every held entry
    input  logic          store_i,     // accepted, non-bubble, non-flushed beat
    input  logic          drain_ok_i,  // downstream ready and not stalled
    input  logic [PW-1:0] data_i,
    output logic          out_valid_o,
    output logic [PW-1:0] out_data_o,
    output logic          in_ready_o,
    output logic [1:0]    occ_o
);

    id_ex_state_e  state_q, state_d;
    logic [PW-1:0] head_q, head_d;
    logic [PW-1:0] skid_q, skid_d;
    logic          in_ready_q, in_ready_d;
    logic          drain;

    assign drain = (state_q != S_EMPTY) && drain_ok_i;

    // Next-state and storage selection; flush overrides any move
    always_comb begin
        state_d = state_q;
        head_d  = head_q;
        skid_d  = skid_q;
        if (flush_i) begin
            state_d = S_EMPTY;
        end else begin
            case (state_q)
                S_EMPTY: begin
                    if (store_i) begin
                        state_d = S_ONE;
                        head_d  = data_i;
                    end
                end
                S_ONE: begin
                    if (store_i && drain) begin
                        head_d = data_i;
                    end else if (store_i) begin
                        state_d = S_TWO;
                        skid_d  = data_i;
                    end else if (drain) begin
                        state_d = S_EMPTY;
                    end
                end
                S_TWO: begin
                    // in_ready is low here, so no store can arrive
                    if (drain) begin
                        state_d = S_ONE;
                        head_d  = skid_q;
                    end
                end
                default: state_d = S_EMPTY;
            endcase
        end
        in_ready_d = (state_d != S_TWO);
    end

    // State, storage and registered ready
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_EMPTY;
            head_q     <= '0;
            skid_q     <= '0;
            in_ready_q <= 1'b1;
        end else begin
            state_q    <= state_d;
            head_q     <= head_d;
            skid_q     <= skid_d;
            in_ready_q <= in_ready_d;
        end
    end

    assign out_valid_o = (state_q != S_EMPTY);
    assign out_data_o  = head_q;
    assign in_ready_o  = in_ready_q;
    assign occ_o       = state_q;

endmodule

// File: rtl/id_ex_stage.sv
// ID->EX pipeline stage: one decoded-instruction payload per beat over a
// valid/ready handshake, with memory stall, flush and bubble squashing.
// Optional macro ID_EX_SKID_EN adds a 2-entry skid buffer with a registered
// in_ready; without it a single register passes out_ready through to in_ready.
//
// Handshake: a beat transfers on a port when valid and ready are both high at
// the rising edge; valid, once raised by the stage, stays high with stable
// data until the beat drains; stl_mm=1 blocks draining exactly like out_ready=0.
// occ equals the FSM state encoding and is the debug view of the state.
module id_ex_stage
    import id_ex_pkg::*;
#(
    parameter int               PW      = ID_EX_PW,
    parameter int               OPC_W   = 7,
    parameter logic [OPC_W-1:0] BUB_OPC = '0,
    parameter int               CNT_W   = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [PW-1:0]    in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [PW-1:0]    out_data,
    input  logic             stl_mm,
    input  logic             flush,
    output logic [1:0]       occ,
    output logic [CNT_W-1:0] bub_cnt
);

    logic             is_bub;
    logic             accept;
    logic             store;
    logic             bub_hit;
    logic             drain_ok;
    logic [CNT_W-1:0] bub_cnt_q, bub_cnt_d;

    assign is_bub   = (in_data[PW-1 -: OPC_W] == BUB_OPC);
    assign accept   = in_valid && in_ready;
    // A flushed beat is discarded whether it is a bubble or not
    assign store    = accept && !is_bub && !flush;
    assign bub_hit  = accept && is_bub && !flush;
    assign drain_ok = out_ready && !stl_mm;

    // Saturating count of squashed bubbles
    always_comb begin
        bub_cnt_d = bub_cnt_q;
        if (bub_hit && (bub_cnt_q != {CNT_W{1'b1}})) begin
            bub_cnt_d = bub_cnt_q + CNT_W'(1);
        end
    end

    // Bubble counter register
    always_ff @(posedge clk) begin
        if (rst) begin
            bub_cnt_q <= '0;
        end else begin
            bub_cnt_q <= bub_cnt_d;
        end
    end

    assign bub_cnt = bub_cnt_q;

`ifdef ID_EX_SKID_EN

    id_ex_skid #(
        .PW (PW)
    ) u_skid (
        .clk         (clk),
        .rst         (rst),
        .flush_i     (flush),
        .store_i     (store),
        .drain_ok_i  (drain_ok),
        .data_i      (in_data),
        .out_valid_o (out_valid),
        .out_data_o  (out_data),
        .in_ready_o  (in_ready),
        .occ_o       (occ)
    );

`else

    id_ex_state_e  state_q, state_d;
    logic [PW-1:0] data_q, data_d;

    // Single-entry next state; a store in ONE replaces the draining beat
    always_comb begin
        state_d = state_q;
        data_d  = data_q;
        if (flush) begin
            state_d = S_EMPTY;
        end else if (store) begin
            state_d = S_ONE;
            data_d  = in_data;
        end else if ((state_q == S_ONE) && drain_ok) begin
            state_d = S_EMPTY;
        end
    end

    // Single-entry state and payload register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_EMPTY;
            data_q  <= '0;
        end else begin
            state_q <= state_d;
            data_q  <= data_d;
        end
    end

    assign out_valid = (state_q == S_ONE);
    assign out_data  = data_q;
    assign in_ready  = !out_valid || drain_ok;
    assign occ       = state_q;

`endif

endmodule

// File: tb/tb_id_ex_stage.sv
// Directed self-checking bench for id_ex_stage. Inputs change just after the
// falling edge; outputs are checked 1 time unit later, away from the rising edge.
module tb_id_ex_stage;

    localparam int PW    = 145;
    localparam int CNT_W = 3;
`ifdef ID_EX_SKID_EN
    localparam bit SKID = 1'b1;
`else
    localparam bit SKID = 1'b0;
`endif

    logic             clk = 1'b0;
    logic             rst;
    logic             in_valid;
    logic             in_ready;
    logic [PW-1:0]    in_data;
    logic             out_valid;
    logic             out_ready;
    logic [PW-1:0]    out_data;
    logic             stl_mm;
    logic             flush;
    logic [1:0]       occ;
    logic [CNT_W-1:0] bub_cnt;

    int total = 0;
    int bad   = 0;

    logic [PW-1:0] exp_q[$];
    logic [6:0]    t4[5];
    logic [31:0]   v4[5];
    logic [31:0]   v2[3];

    // Clock
    always #5 clk = ~clk;

    id_ex_stage #(
        .CNT_W (CNT_W)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .stl_mm    (stl_mm),
        .flush     (flush),
        .occ       (occ),
        .bub_cnt   (bub_cnt)
    );

    // Payload with opcode t at the MSBs and a tag in the low 32 bits
    function automatic logic [PW-1:0] mk(input logic [6:0] t, input logic [31:0] v);
        return {t, {(PW-39){1'b0}}, v};
    endfunction

    task automatic chk(input string tag, input logic [PW-1:0] obs, input logic [PW-1:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    initial begin
        t4 = '{7'h13, 7'h00, 7'h00, 7'h00, 7'h13};
        v4 = '{32'h44, 32'hB1, 32'hB2, 32'hB3, 32'h55};
        v2 = '{32'h11, 32'h22, 32'h33};

        // 1: reset with a live beat offered
        rst = 1'b1; in_valid = 1'b1; in_data = mk(7'h13, 32'hAA);
        out_ready = 1'b0; stl_mm = 1'b0; flush = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        chk("rst_out_valid", out_valid, 0);
        chk("rst_occ", occ, 0);
        chk("rst_bub_cnt", bub_cnt, 0);
        chk("rst_out_data", out_data, 0);
        @(negedge clk); rst = 1'b0;
        #1 chk("rst_in_ready", in_ready, 1);
        @(negedge clk); in_valid = 1'b0; out_ready = 1'b1;
        #1;
        chk("t1_valid", out_valid, 1);
        chk("t1_data", out_data, mk(7'h13, 32'hAA));
        chk("t1_occ", occ, 1);
        @(negedge clk);
        #1 chk("t1_drained", out_valid, 0);

        // 2: stream at full throughput
        @(negedge clk); in_valid = 1'b1; in_data = mk(7'h13, v2[0]); exp_q.push_back(in_data);
        for (int i = 1; i <= 3; i++) begin
            @(negedge clk);
            if (i < 3) begin
                in_data = mk(7'h13, v2[i]);
                exp_q.push_back(in_data);
            end else begin
                in_valid = 1'b0;
            end
            #1;
            chk("t2_valid", out_valid, 1);
            chk("t2_data", out_data, exp_q.pop_front());
            chk("t2_occ", occ, 1);
        end
        @(negedge clk);
        #1 chk("t2_empty", out_valid, 0);

        // 3: backpressure fills the stage, then release
        @(negedge clk); out_ready = 1'b0; in_valid = 1'b1;
        in_data = mk(7'h13, 32'h11); exp_q.push_back(in_data);
        @(negedge clk); in_data = mk(7'h13, 32'h22); exp_q.push_back(in_data);
        #1;
        chk("t3_occ1", occ, 1);
        chk("t3_head", out_data, mk(7'h13, 32'h11));
        @(negedge clk);
        #1;
        chk("t3_occ_full", occ, SKID ? 2 : 1);
        chk("t3_in_ready", in_ready, 0);
        chk("t3_out0", out_data, exp_q.pop_front());
        out_ready = 1'b1;
`ifdef ID_EX_SKID_EN
        in_valid = 1'b0;
`endif
        @(negedge clk); in_valid = 1'b0;
        #1;
        chk("t3_valid1", out_valid, 1);
        chk("t3_out1", out_data, exp_q.pop_front());
        chk("t3_occ_after", occ, 1);
        @(negedge clk);
        #1;
        chk("t3_empty", out_valid, 0);
        chk("t3_no_dup", exp_q.size(), 0);

        // 4: bubbles interleaved with real beats
        @(negedge clk); in_valid = 1'b1; in_data = mk(t4[0], v4[0]);
        for (int i = 1; i <= 5; i++) begin
            @(negedge clk);
            if (i < 5) in_data = mk(t4[i], v4[i]);
            else in_valid = 1'b0;
            #1;
            chk("t4_valid", out_valid, (t4[i-1] != 7'h00));
            if (t4[i-1] != 7'h00) chk("t4_data", out_data, mk(t4[i-1], v4[i-1]));
        end
        #1 chk("t4_bub_cnt", bub_cnt, 3);
        @(negedge clk);
        #1 chk("t4_empty", out_valid, 0);

        // 5: flush with the stage full and a beat offered
        @(negedge clk); out_ready = 1'b0; in_valid = 1'b1; in_data = mk(7'h13, 32'h66);
        @(negedge clk); in_data = mk(7'h13, 32'h77);
        #1 chk("t5_head", out_data, mk(7'h13, 32'h66));
        @(negedge clk); flush = 1'b1; in_data = mk(7'h13, 32'h88);
        #1 chk("t5_occ_full", occ, SKID ? 2 : 1);
        @(negedge clk);
        #1;
        chk("t5_flush_valid", out_valid, 0);
        chk("t5_flush_occ", occ, 0);
        out_ready = 1'b1; in_data = mk(7'h13, 32'h99);
        @(negedge clk); in_data = mk(7'h00, 32'h0);
        #1;
        chk("t5_disc_valid", out_valid, 0);
        chk("t5_disc_occ", occ, 0);
        @(negedge clk); flush = 1'b0; in_valid = 1'b0;
        #1;
        chk("t5_bub_unchanged", bub_cnt, 3);
        chk("t5_still_empty", out_valid, 0);

        // 6: memory stall freezes the head
        @(negedge clk); stl_mm = 1'b1; out_ready = 1'b1; in_valid = 1'b1;
        in_data = mk(7'h13, 32'hAB);
        @(negedge clk); in_valid = 1'b0;
        for (int i = 0; i < 4; i++) begin
            #1;
            chk("t6_valid", out_valid, 1);
            chk("t6_data", out_data, mk(7'h13, 32'hAB));
            chk("t6_occ", occ, 1);
            chk("t6_in_ready", in_ready, SKID ? 1 : 0);
            @(negedge clk);
        end
        stl_mm = 1'b0;
        #1 chk("t6_held", out_valid, 1);
        @(negedge clk);
        #1 chk("t6_drained", out_valid, 0);

        // 7: bubble counter saturates
        @(negedge clk); in_valid = 1'b1; in_data = mk(7'h00, 32'h5);
        repeat (4) @(negedge clk);
        #1 chk("t7_bub_max", bub_cnt, 7);
        repeat (2) @(negedge clk);
        in_valid = 1'b0;
        #1;
        chk("t7_bub_sat", bub_cnt, 7);
        chk("t7_no_out", out_valid, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
